// File: rtl/mul_shift_add_ctrl.sv
// rtl/mul_shift_add_ctrl.sv - sequential N x N shift-and-add multiplier controller driving an external ripple adder
// Optional macro MUL_HIGH_NZ_EN adds the registered hi_nz flag (product exceeds N bits).
module mul_shift_add_ctrl #(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] prod,
`ifdef MUL_HIGH_NZ_EN
    output logic           hi_nz,
`endif
    output logic [N-1:0]   add_x1,
    output logic [N-1:0]   add_x2,
    output logic           add_ripin,
    input  logic [N-1:0]   add_somma,
    input  logic           add_ripout
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     h_q, h_d;
    logic [N-1:0]     l_q, l_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;
`ifdef MUL_HIGH_NZ_EN
    logic             hi_nz_q, hi_nz_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef MUL_HIGH_NZ_EN
            hi_nz_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`ifdef MUL_HIGH_NZ_EN
            hi_nz_q <= hi_nz_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        h_d       = h_q;
        l_d       = l_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
`ifdef MUL_HIGH_NZ_EN
        hi_nz_d   = hi_nz_q;
`endif
        add_x1    = '0;
        add_x2    = '0;
        add_ripin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    h_d     = '0;
                    l_d     = b;
                    cnt_d   = CW'(N);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_x1 = h_q;
                add_x2 = l_q[0] ? m_q : '0;
                // Carry-out re-enters the top of H so the running sum never loses a bit.
                h_d    = {add_ripout, add_somma[N-1:1]};
                l_d    = {add_somma[0], l_q[N-1:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    prod_d  = {h_d, l_d};
`ifdef MUL_HIGH_NZ_EN
                    hi_nz_d = |h_d;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign prod  = prod_q;
`ifdef MUL_HIGH_NZ_EN
    assign hi_nz = hi_nz_q;
`endif

endmodule

// File: tb/tb_mul_shift_add_ctrl.sv
// tb/tb_mul_shift_add_ctrl.sv - directed scoreboard bench for mul_shift_add_ctrl with a behavioural adder
module tb_mul_shift_add_ctrl;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [N-1:0]   a, b;
    logic           busy, done;
    logic [2*N-1:0] prod;
    logic [N-1:0]   add_x1, add_x2, add_somma;
    logic           add_ripin, add_ripout;
`ifdef MUL_HIGH_NZ_EN
    logic           hi_nz;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;
    logic [2*N-1:0] sb_q[$];

    always #5 clk = ~clk;

    assign {add_ripout, add_somma} = {1'b0, add_x1} + {1'b0, add_x2} + {{N{1'b0}}, add_ripin};

    mul_shift_add_ctrl #(.N(N)) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .prod       (prod),
`ifdef MUL_HIGH_NZ_EN
        .hi_nz      (hi_nz),
`endif
        .add_x1     (add_x1),
        .add_x2     (add_x2),
        .add_ripin  (add_ripin),
        .add_somma  (add_somma),
        .add_ripout (add_ripout)
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the done cycle, at the abort point, or when the budget expires.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv, input int ign_at,
                          input int rst_at, output int lat, output int busy_cyc, output logic x2_nz);
        logic [2*N-1:0] exp;
        lat = 0;
        busy_cyc = 0;
        x2_nz = 1'b0;
        start = 1'b1;
        a = ta;
        b = tbv;
        sb_q.push_back({{N{1'b0}}, ta} * {{N{1'b0}}, tbv});
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a = N'($urandom);
                b = N'($urandom);
            end
            if (busy) busy_cyc++;
            if (busy && add_x2 != '0) x2_nz = 1'b1;
            if (rst_at == i) begin
                reset_n = 1'b0;
                sb_q.delete();
                return;
            end
            if (ign_at != 0 && i == ign_at) begin
                start = 1'b1;
                a = 8'd7;
                b = 8'd7;
            end
            if (ign_at != 0 && i == ign_at + 1) start = 1'b0;
            if (done) begin
                lat = i;
                exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
                check("prod", 32'(prod), 32'(exp));
`ifdef MUL_HIGH_NZ_EN
                check("hi_nz", 32'(hi_nz), 32'(|exp[2*N-1:N]));
`endif
                return;
            end
        end
    endtask

    initial begin
        int   lat, bc, d0;
        logic x2;
        reset_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_prod", 32'(prod), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_x1", 32'(add_x1), 32'h0);
        check("rst_x2", 32'(add_x2), 32'h0);
        check("rst_ripin", 32'(add_ripin), 32'h0);

        run_op(8'd13, 8'd11, 0, 0, lat, bc, x2);
        check("basic_lat", 32'(lat), 32'd9);
        check("basic_busy", 32'(bc), 32'd9);
        @(negedge clk);
        check("pulse_done", 32'(done), 32'h0);
        check("pulse_busy", 32'(busy), 32'h0);
        check("hold_prod", 32'(prod), 32'h008F);
        check("idle_x1", 32'(add_x1), 32'h0);

        run_op(8'hFF, 8'hFF, 0, 0, lat, bc, x2);
        check("carry_lat", 32'(lat), 32'd9);
        @(negedge clk);
        run_op(8'hFF, 8'h00, 0, 0, lat, bc, x2);
        check("zero_lat", 32'(lat), 32'd9);
        check("zero_x2", 32'(x2), 32'h0);
        @(negedge clk);
        run_op(8'd2, 8'd3, 0, 0, lat, bc, x2);
        check("b2b_lat", 32'(lat), 32'd9);

        @(negedge clk);
        d0 = done_cnt;
        run_op(8'd3, 8'd5, 4, 0, lat, bc, x2);
        check("ign_lat", 32'(lat), 32'd9);
        repeat (12) @(negedge clk);
        check("ign_dones", 32'(done_cnt - d0), 32'd1);
        check("ign_prod", 32'(prod), 32'd15);
        check("ign_busy", 32'(busy), 32'h0);

        d0 = done_cnt;
        run_op(8'd9, 8'd9, 0, 5, lat, bc, x2);
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_prod", 32'(prod), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_x1", 32'(add_x1), 32'h0);
`ifdef MUL_HIGH_NZ_EN
        check("abort_hinz", 32'(hi_nz), 32'h0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_nodone", 32'(done_cnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_shift_add_ctrl.md
Name: mul_shift_add_ctrl

Overview:
- Sequential unsigned N×N shift-and-add multiplier controller. It sits directly upstream of the team's combinational N-bit ripple adder (fulladder_Nbit) and also consumes that adder's result.
- It drives the adder's operands and carry-in every cycle, then captures the sum and carry-out into a 2N-bit partial-product register.
- The adder is instantiated externally, at the parent level, and wired through the add_* ports.

Parameters:
- N, 8, operand width; must equal the N of the attached adder; legal range ≥ 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  N  multiplicand; captured when start is accepted.
- b  in  N  multiplier; captured when start is accepted.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; prod is valid in this cycle.
- prod  out  2N  product; held until the next accepted start.
- add_x1  out  N  adder operand 1.
- add_x2  out  N  adder operand 2.
- add_ripin  out  1  adder carry-in; constant 0.
- add_somma  in  N  adder sum.
- add_ripout  in  1  adder carry-out.

Behaviour:
- Registers:
  - M[N-1:0]: multiplicand.
  - H[N-1:0]: high half.
  - L[N-1:0]: low half, initially the multiplier.
  - cnt: ceil(log2(N+1)) bits.
  - state: IDLE, RUN or DONE.
- Reset (asynchronous, whenever reset_n=0):
  - state=IDLE; M, H, L, cnt = 0.
  - prod=0, done=0, busy=0.
  - Reset in any state, including mid-RUN, aborts the operation with no done pulse.
- IDLE:
  - If start=1: M←a, H←0, L←b, cnt←N, go to RUN.
  - Otherwise hold all registers.
- RUN, one multiplier bit per cycle, combinational through the external adder:
  - add_x1=H.
  - add_x2 = L[0] ? M : 0.
  - add_ripin=0.
  - On the clock edge: H←{add_ripout, add_somma[N-1:1]}, L←{add_somma[0], L[N-1:1]}, cnt←cnt−1.
  - When cnt==1 at the edge: go to DONE.
- DONE:
  - prod={H,L} is loaded on entry to DONE; done=1 for exactly this one cycle; go to IDLE.
- Adder-operand outputs: add_x1 and add_x2 are 0 whenever state≠RUN.
- Latency: start accepted at edge t → N RUN cycles → done high in the cycle after edge t+N. From start to the done pulse is N+1 cycles; N=8 gives 9.
- start is ignored in RUN and DONE; no queuing.
- A start asserted in the IDLE cycle right after DONE is accepted (back-to-back operation).
- Arithmetic is unsigned. The final carry is always absorbed into H, so the product never overflows 2N bits.
- The carry path from add_ripout is mandatory: it is what makes all-ones operands correct.
- prod changes only on the DONE load and on reset.
- The a/b inputs may change freely after acceptance.

Optional Feature:
- Macro MUL_HIGH_NZ_EN.
- Defined:
  - Adds output port hi_nz (1 bit) = |prod[2N-1:N], registered together with prod.
  - Resets to 0; held like prod.
  - Flags that the product does not fit in N bits.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: reset_n=0 for 2 cycles, then release → prod=0, done=0, busy=0, add_x1=add_x2=0.
- Basic product, N=8: start with a=13, b=11 → done exactly 9 cycles after the accepting edge; prod=0x008F (143); done high for 1 cycle; busy high for 9 cycles. With MUL_HIGH_NZ_EN defined, hi_nz=0.
- Carry path: a=0xFF, b=0xFF → prod=0xFE01. With MUL_HIGH_NZ_EN defined, hi_nz=1.
- Zero multiplier: a=0xFF, b=0x00 → prod=0x0000; add_x2 stays 0 in every RUN cycle.
- Ignored start: start a=3, b=5, then pulse start with a=7, b=7 in RUN cycle 4 → prod=15; only one done pulse.
- Back-to-back and abort:
  - Start a=2, b=3 again in the IDLE cycle after done → prod=6 nine cycles later.
  - Then start a=9, b=9 and assert reset_n=0 in RUN cycle 5 → immediately IDLE, prod=0, no done pulse.
